// File: rtl/emmk_xmem_pkg.sv
// Shared types and pin_ctrl bit map for the byte-serial external memory master.
package emmk_xmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_TURN,
        ST_RDATA,
        ST_RESP
    } state_e;

    localparam int CTRL_STB    = 0;
    localparam int CTRL_WE     = 1;
    localparam int CTRL_LAST   = 2;
    localparam int CTRL_PHASE  = 3;
    localparam int CTRL_BE_LSB = 4;

    localparam int DATA_BYTES  = 4;

    // States in which a strobed beat is waiting on pin_ack.
    function automatic logic is_beat_state(input state_e s);
        return (s == ST_ADDR) || (s == ST_WDATA) || (s == ST_RDATA);
    endfunction

    // we/be/last/phase only ever appear alongside the strobe.
    function automatic logic [7:0] pack_ctrl(input logic       stb,
                                             input logic       we,
                                             input logic       last,
                                             input logic       phase,
                                             input logic [3:0] be);
        logic [7:0] c;
        c = '0;
        if (stb) begin
            c[CTRL_STB]            = 1'b1;
            c[CTRL_WE]             = we;
            c[CTRL_LAST]           = last;
            c[CTRL_PHASE]          = phase;
            c[CTRL_BE_LSB +: 4]    = be;
        end
        return c;
    endfunction

endpackage

// File: rtl/emmk_xmem_master_beat_timer.sv
// Per-beat wait counter; flags the cycle on which the responder has stalled too long.
module emmk_xmem_master_beat_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    if (TIMEOUT == 0) begin : g_never
        assign expired_o = 1'b0;
    end else begin : g_count
        localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (clr_i) begin
                cnt_q <= '0;
            end else if (en_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        // Fires on the TIMEOUT-th consecutive cycle of a beat without ack.
        assign expired_o = en_i && !clr_i && (cnt_q == LIMIT);
    end

endmodule

// File: rtl/emmk_xmem_master.sv
// External memory initiator: serialises 32-bit load/store requests into
// strobe/ack paced byte beats on the TinyTapeout uo/uio pads.
module emmk_xmem_master
    import emmk_xmem_pkg::*;
#(
    parameter int ADDR_BYTES = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [3:0]              req_be,
    input  logic [8*ADDR_BYTES-1:0] req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic [7:0]              pin_ctrl,
    output logic [7:0]              pin_dout,
    output logic [7:0]              pin_oe,
    input  logic [7:0]              pin_din,
    input  logic                    pin_ack
);

    localparam int AW        = 8 * ADDR_BYTES;
    localparam int MAX_BYTES = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_BYTES - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BYTES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] beat_q,  beat_d;
    logic             we_q,    we_d;
    logic [3:0]       be_q,    be_d;
    logic [AW-1:0]    addr_q,  addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      asm_q,   asm_d;

    logic             idle_q;
    logic             rsp_valid_q, rsp_err_q;
    logic [31:0]      rsp_rdata_q;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [7:0]       dout_q, dout_d;
    logic [7:0]       oe_q,   oe_d;

    logic             beat_st;
    logic             expired;

    assign beat_st = is_beat_state(state_q);

    emmk_xmem_master_beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (pin_ack || !beat_st),
        .en_i      (beat_st),
        .expired_o (expired)
    );

    // idle_q stays low through reset so req_ready is 0 while rst_n is asserted.
    assign req_ready = ena && idle_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign pin_ctrl  = ctrl_q;
    assign pin_dout  = dout_q;
    assign pin_oe    = oe_q;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    be_d    = req_be;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    asm_d   = '0;
                    beat_d  = '0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (pin_ack) begin
                    if (beat_q == ADDR_LAST) begin
                        beat_d  = '0;
                        state_d = we_q ? ST_WDATA : ST_TURN;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_WDATA: begin
                if (pin_ack) begin
                    if (beat_q == DATA_LAST) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_TURN: begin
                beat_d  = '0;
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                if (pin_ack) begin
                    // asm_q was cleared on accept, so OR-ing in lane k is a plain write.
                    asm_d = asm_q | (32'(pin_din) << {beat_q, 3'b000});
                    if (beat_q == DATA_LAST) begin
                        state_d = ST_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else if (expired) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pad values decoded from the next state so they leave a flop aligned with state_q.
    always_comb begin
        ctrl_d = '0;
        dout_d = '0;
        oe_d   = '0;
        unique case (state_d)
            ST_ADDR: begin
                ctrl_d = pack_ctrl(1'b1, we_d, beat_d == ADDR_LAST, 1'b0, be_d);
                dout_d = 8'(addr_d >> {ADDR_LAST - beat_d, 3'b000});
                oe_d   = 8'hFF;
            end
            ST_WDATA: begin
                ctrl_d = pack_ctrl(1'b1, we_d, beat_d == DATA_LAST, 1'b1, be_d);
                dout_d = 8'(wdata_d >> {beat_d, 3'b000});
                oe_d   = 8'hFF;
            end
            ST_RDATA: begin
                ctrl_d = pack_ctrl(1'b1, we_d, beat_d == DATA_LAST, 1'b1, be_d);
            end
            default: begin
                ctrl_d = '0;
            end
        endcase
    end

    // NOTE: state and outputs update with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            idle_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            ctrl_q      <= '0;
            dout_q      <= '0;
            oe_q        <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            we_q        <= we_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            asm_q       <= asm_d;
            idle_q      <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_d == ST_RESP);
            rsp_err_q   <= (state_d == ST_RESP) && expired;
            ctrl_q      <= ctrl_d;
            dout_q      <= dout_d;
            oe_q        <= oe_d;
            if (state_d == ST_RESP && state_q != ST_RESP) begin
                rsp_rdata_q <= (expired || we_q) ? 32'h0 : asm_d;
            end
        end
    end

endmodule
